// File: rtl/lcd_arbiter.sv
// -----------------------------------------------------------------------------
// lcd_arbiter
//   Shares one LCD character-write port between NUM_REQ requesters.
//   Grants are round-robin and message-atomic: the owner keeps the port until
//   its character flagged 'last' has been accepted by the LCD. Characters are
//   handed to the LCD with a data_ready / lcd_busy handshake. If the LCD never
//   raises lcd_busy within TIMEOUT_CYCLES, the message is dropped.
//
// Ports
//   clock            in   system clock, rising edge
//   internal_reset_n in   asynchronous active-low reset
//   req              in   per-requester request, held for the whole message
//   char_in          in   per-requester character, slice i = [i*DATA_W +: DATA_W]
//   last             in   per-requester "current char ends the message"
//   grant            out  one-hot owner of the LCD, zero when idle
//   char_ack         out  one-cycle pulse on the owner's bit: char accepted
//   lcd_busy         in   LCD busy flag (synchronous to clock)
//   lcd_data         out  character presented to the LCD
//   data_ready       out  lcd_data is valid
//   timeout          out  one-cycle pulse: LCD never accepted, message dropped
// -----------------------------------------------------------------------------
module lcd_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                      clock,
    input  logic                      internal_reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] char_in,
    input  logic [NUM_REQ-1:0]        last,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        char_ack,
    input  logic                      lcd_busy,
    output logic [DATA_W-1:0]         lcd_data,
    output logic                      data_ready,
    output logic                      timeout
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_FREE = 2'd1,
        S_PRESENT   = 2'd2
    } state_t;

    state_t                state_q;
    logic [NUM_REQ-1:0]    grant_q;
    logic [NUM_REQ-1:0]    char_ack_q;
    logic [DATA_W-1:0]     lcd_data_q;
    logic                  data_ready_q;
    logic                  timeout_q;
    logic                  last_q;
    logic [IDX_W-1:0]      gidx_q;
    logic [IDX_W-1:0]      ptr_q;
    logic [CNT_W-1:0]      cnt_q;

    logic [DATA_W-1:0]     char_arr_s [NUM_REQ];
    logic                  found_s;
    logic [IDX_W-1:0]      winner_s;
    logic [IDX_W:0]        cand_s;

    // Index following idx, wrapping at NUM_REQ (pointer advance on release).
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        if (idx == IDX_W'(NUM_REQ - 1)) begin
            next_idx = '0;
        end else begin
            next_idx = idx + IDX_W'(1);
        end
    endfunction

    // One-hot vector with bit idx set.
    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        onehot = NUM_REQ'(1) << idx;
    endfunction

    // Unpack the flat character bus so the owner's char can be picked by index.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign char_arr_s[gi] = char_in[gi*DATA_W +: DATA_W];
    end

    // Round-robin search: scan from ptr_q upward, wrapping, first req wins.
    always_comb begin
        found_s  = 1'b0;
        winner_s = '0;
        cand_s   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_s = {1'b0, ptr_q} + (IDX_W+1)'(i);
            if (cand_s >= (IDX_W+1)'(NUM_REQ)) begin
                cand_s = cand_s - (IDX_W+1)'(NUM_REQ);
            end else begin
                cand_s = cand_s;
            end
            if (!found_s && req[cand_s[IDX_W-1:0]]) begin
                winner_s = cand_s[IDX_W-1:0];
                found_s  = 1'b1;
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Arbitration / handshake FSM with all outputs registered.
    always_ff @(posedge clock or negedge internal_reset_n) begin
        if (!internal_reset_n) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            char_ack_q   <= '0;
            lcd_data_q   <= '0;
            data_ready_q <= 1'b0;
            timeout_q    <= 1'b0;
            last_q       <= 1'b0;
            gidx_q       <= '0;
            ptr_q        <= '0;
            cnt_q        <= '0;
        end else begin
            // ack and timeout are single-cycle pulses
            char_ack_q <= '0;
            timeout_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (found_s) begin
                        grant_q <= onehot(winner_s);
                        gidx_q  <= winner_s;
                        state_q <= S_WAIT_FREE;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_WAIT_FREE: begin
                    if (!req[gidx_q]) begin
                        // requester abandoned the message: release without ack
                        grant_q <= '0;
                        ptr_q   <= next_idx(gidx_q);
                        state_q <= S_IDLE;
                    end else if (!lcd_busy) begin
                        lcd_data_q   <= char_arr_s[gidx_q];
                        last_q       <= last[gidx_q];
                        data_ready_q <= 1'b1;
                        cnt_q        <= '0;
                        state_q      <= S_PRESENT;
                    end else begin
                        state_q <= S_WAIT_FREE;
                    end
                end
                S_PRESENT: begin
                    // req changes are ignored here; the char is already latched
                    if (lcd_busy) begin
                        data_ready_q <= 1'b0;
                        char_ack_q   <= grant_q;
                        if (last_q) begin
                            grant_q <= '0;
                            ptr_q   <= next_idx(gidx_q);
                            state_q <= S_IDLE;
                        end else begin
                            state_q <= S_WAIT_FREE;
                        end
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        data_ready_q <= 1'b0;
                        timeout_q    <= 1'b1;
                        grant_q      <= '0;
                        ptr_q        <= next_idx(gidx_q);
                        state_q      <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    grant_q      <= '0;
                    data_ready_q <= 1'b0;
                    state_q      <= S_IDLE;
                end
            endcase
        end
    end

    assign grant      = grant_q;
    assign char_ack   = char_ack_q;
    assign lcd_data   = lcd_data_q;
    assign data_ready = data_ready_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_lcd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_lcd_arbiter
//   Directed cycle table for a single message, abort and round-robin
//   contention, hand-written sequences for timeout and asynchronous reset,
//   then a randomized run with an LCD model and per-requester sequence
//   numbers that checks the invariants and char order.
// -----------------------------------------------------------------------------
module tb_lcd_arbiter;

    logic        clock;
    logic        internal_reset_n;
    logic [1:0]  req;
    logic [15:0] char_in;
    logic [1:0]  last;
    logic [1:0]  grant;
    logic [1:0]  char_ack;
    logic        lcd_busy;
    logic [7:0]  lcd_data;
    logic        data_ready;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    lcd_arbiter #(
        .NUM_REQ        (2),
        .DATA_W         (8),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clock            (clock),
        .internal_reset_n (internal_reset_n),
        .req              (req),
        .char_in          (char_in),
        .last             (last),
        .grant            (grant),
        .char_ack         (char_ack),
        .lcd_busy         (lcd_busy),
        .lcd_data         (lcd_data),
        .data_ready       (data_ready),
        .timeout          (timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] g, input logic [1:0] a,
                           input logic dr, input logic [7:0] d, input logic to);
        chk({tag, "_grant"}, 32'(grant), 32'(g));
        chk({tag, "_ack"}, 32'(char_ack), 32'(a));
        chk({tag, "_dr"}, 32'(data_ready), 32'(dr));
        chk({tag, "_data"}, 32'(lcd_data), 32'(d));
        chk({tag, "_to"}, 32'(timeout), 32'(to));
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    typedef struct packed {
        logic [1:0] req;
        logic [1:0] last;
        logic [7:0] c0;
        logic [7:0] c1;
        logic       busy;
        logic [1:0] e_grant;
        logic [1:0] e_ack;
        logic       e_dr;
        logic [7:0] e_data;
        logic       e_to;
    } vec_t;

    localparam int NV = 26;
    vec_t vecs [NV];

    logic [6:0] seq [2];
    logic [1:0] prev_grant;
    logic       prev_dr;
    logic [7:0] exp_c;
    int         acks;

    initial begin
        // req last c0 c1 busy | grant ack dr data to
        // single message "AB" from requester 0
        vecs[0]  = '{2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0};
        vecs[1]  = '{2'b01, 2'b00, 8'h41, 8'h00, 1'b0, 2'b01, 2'b00, 1'b0, 8'h00, 1'b0};
        vecs[2]  = '{2'b01, 2'b00, 8'h41, 8'h00, 1'b0, 2'b01, 2'b00, 1'b1, 8'h41, 1'b0};
        vecs[3]  = '{2'b01, 2'b00, 8'h41, 8'h00, 1'b1, 2'b01, 2'b01, 1'b0, 8'h41, 1'b0};
        vecs[4]  = '{2'b01, 2'b01, 8'h42, 8'h00, 1'b1, 2'b01, 2'b00, 1'b0, 8'h41, 1'b0};
        vecs[5]  = '{2'b01, 2'b01, 8'h42, 8'h00, 1'b1, 2'b01, 2'b00, 1'b0, 8'h41, 1'b0};
        vecs[6]  = '{2'b01, 2'b01, 8'h42, 8'h00, 1'b0, 2'b01, 2'b00, 1'b1, 8'h42, 1'b0};
        vecs[7]  = '{2'b01, 2'b01, 8'h42, 8'h00, 1'b0, 2'b01, 2'b00, 1'b1, 8'h42, 1'b0};
        vecs[8]  = '{2'b01, 2'b01, 8'h42, 8'h00, 1'b1, 2'b00, 2'b01, 1'b0, 8'h42, 1'b0};
        vecs[9]  = '{2'b00, 2'b00, 8'h42, 8'h00, 1'b1, 2'b00, 2'b00, 1'b0, 8'h42, 1'b0};
        // abort: requester 1 drops req in WAIT_FREE while busy (pointer is 1)
        vecs[10] = '{2'b10, 2'b00, 8'h00, 8'h55, 1'b1, 2'b10, 2'b00, 1'b0, 8'h42, 1'b0};
        vecs[11] = '{2'b10, 2'b00, 8'h00, 8'h55, 1'b1, 2'b10, 2'b00, 1'b0, 8'h42, 1'b0};
        vecs[12] = '{2'b00, 2'b00, 8'h00, 8'h55, 1'b1, 2'b00, 2'b00, 1'b0, 8'h42, 1'b0};
        vecs[13] = '{2'b00, 2'b00, 8'h00, 8'h55, 1'b0, 2'b00, 2'b00, 1'b0, 8'h42, 1'b0};
        // contention with pointer 0, requester 0 re-asserts after its message
        vecs[14] = '{2'b11, 2'b11, 8'h30, 8'h31, 1'b0, 2'b01, 2'b00, 1'b0, 8'h42, 1'b0};
        vecs[15] = '{2'b11, 2'b11, 8'h30, 8'h31, 1'b0, 2'b01, 2'b00, 1'b1, 8'h30, 1'b0};
        vecs[16] = '{2'b11, 2'b11, 8'h30, 8'h31, 1'b1, 2'b00, 2'b01, 1'b0, 8'h30, 1'b0};
        vecs[17] = '{2'b11, 2'b11, 8'h32, 8'h31, 1'b1, 2'b10, 2'b00, 1'b0, 8'h30, 1'b0};
        vecs[18] = '{2'b11, 2'b11, 8'h32, 8'h31, 1'b1, 2'b10, 2'b00, 1'b0, 8'h30, 1'b0};
        vecs[19] = '{2'b11, 2'b11, 8'h32, 8'h31, 1'b0, 2'b10, 2'b00, 1'b1, 8'h31, 1'b0};
        vecs[20] = '{2'b11, 2'b11, 8'h32, 8'h31, 1'b0, 2'b10, 2'b00, 1'b1, 8'h31, 1'b0};
        vecs[21] = '{2'b11, 2'b11, 8'h32, 8'h31, 1'b1, 2'b00, 2'b10, 1'b0, 8'h31, 1'b0};
        vecs[22] = '{2'b01, 2'b11, 8'h32, 8'h31, 1'b1, 2'b01, 2'b00, 1'b0, 8'h31, 1'b0};
        vecs[23] = '{2'b01, 2'b11, 8'h32, 8'h31, 1'b0, 2'b01, 2'b00, 1'b1, 8'h32, 1'b0};
        vecs[24] = '{2'b01, 2'b11, 8'h32, 8'h31, 1'b1, 2'b00, 2'b01, 1'b0, 8'h32, 1'b0};
        vecs[25] = '{2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 2'b00, 2'b00, 1'b0, 8'h32, 1'b0};

        internal_reset_n = 1'b0;
        req      = 2'b00;
        char_in  = 16'h0000;
        last     = 2'b00;
        lcd_busy = 1'b0;
        step();
        chk_all("reset", 2'b00, 2'b00, 1'b0, 8'h00, 1'b0);
        @(negedge clock);
        internal_reset_n = 1'b1;

        // ---------------- table-driven vectors ----------------
        for (int k = 0; k < NV; k++) begin
            req      = vecs[k].req;
            last     = vecs[k].last;
            char_in  = {vecs[k].c1, vecs[k].c0};
            lcd_busy = vecs[k].busy;
            step();
            chk_all($sformatf("v%0d", k), vecs[k].e_grant, vecs[k].e_ack,
                    vecs[k].e_dr, vecs[k].e_data, vecs[k].e_to);
        end

        // ---------------- timeout: pointer is 1, busy stuck low ----------------
        req = 2'b10; last = 2'b10; char_in = {8'h77, 8'h00}; lcd_busy = 1'b0;
        step();
        chk_all("to_grant", 2'b10, 2'b00, 1'b0, 8'h32, 1'b0);
        step();
        chk_all("to_present", 2'b10, 2'b00, 1'b1, 8'h77, 1'b0);
        for (int k = 1; k < 16; k++) begin
            step();
            chk_all($sformatf("to_hold%0d", k), 2'b10, 2'b00, 1'b1, 8'h77, 1'b0);
        end
        step();
        chk_all("to_fire", 2'b00, 2'b00, 1'b0, 8'h77, 1'b1);
        req = 2'b00;
        step();
        chk_all("to_after", 2'b00, 2'b00, 1'b0, 8'h77, 1'b0);

        // ---------------- reset mid-PRESENT ----------------
        // requester 0 sends one char so the pointer moves to 1
        req = 2'b01; last = 2'b01; char_in = {8'h00, 8'h11}; lcd_busy = 1'b0;
        step();
        step();
        lcd_busy = 1'b1;
        step();
        chk_all("rs_msg0", 2'b00, 2'b01, 1'b0, 8'h11, 1'b0);
        req = 2'b00; lcd_busy = 1'b0;
        step();
        req = 2'b10; last = 2'b10; char_in = {8'h22, 8'h11};
        step();
        step();
        chk_all("rs_present", 2'b10, 2'b00, 1'b1, 8'h22, 1'b0);
        #1;
        internal_reset_n = 1'b0;
        #1;
        chk_all("rs_async", 2'b00, 2'b00, 1'b0, 8'h00, 1'b0);
        @(negedge clock);
        internal_reset_n = 1'b1;
        req = 2'b11; last = 2'b11; char_in = {8'h22, 8'h11}; lcd_busy = 1'b0;
        step();
        chk_all("rs_ptr0", 2'b01, 2'b00, 1'b0, 8'h00, 1'b0);
        step();
        chk_all("rs_noack", 2'b01, 2'b00, 1'b1, 8'h11, 1'b0);

        // ---------------- randomized run ----------------
        internal_reset_n = 1'b0;
        req = 2'b00; last = 2'b00; lcd_busy = 1'b0;
        seq[0] = 7'd0; seq[1] = 7'd0;
        char_in = 16'h8000;
        step();
        @(negedge clock);
        internal_reset_n = 1'b1;
        prev_grant = 2'b00;
        prev_dr    = 1'b0;
        acks       = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            step();
            chk("rnd_onehot", 32'($countones(grant) <= 1), 32'd1);
            chk("rnd_ack_owner", 32'(char_ack & ~prev_grant), 32'd0);
            chk("rnd_dr_grant", 32'(!data_ready || (grant != 2'b00)), 32'd1);
            if (prev_dr && data_ready) begin
                chk("rnd_grant_stable", 32'(grant), 32'(prev_grant));
            end
            if (data_ready) begin
                exp_c = {grant[1], seq[grant[1]]};
                chk("rnd_order", 32'(lcd_data), 32'(exp_c));
            end
            // requesters: advance on ack, drop req after the last char
            for (int i = 0; i < 2; i++) begin
                if (char_ack[i]) begin
                    acks++;
                    seq[i] = seq[i] + 7'd1;
                    if (last[i]) begin
                        req[i] = 1'b0;
                    end else begin
                        last[i] = ($urandom_range(0, 2) == 0);
                    end
                end else if (!req[i] && ($urandom_range(0, 3) == 0)) begin
                    req[i]  = 1'b1;
                    last[i] = ($urandom_range(0, 2) == 0);
                end
            end
            char_in = {1'b1, seq[1], 1'b0, seq[0]};
            // LCD model: goes busy some time after data_ready, then frees up
            if (!lcd_busy && data_ready && ($urandom_range(0, 3) != 0)) begin
                lcd_busy = 1'b1;
            end else if (lcd_busy && ($urandom_range(0, 1) == 1)) begin
                lcd_busy = 1'b0;
            end
            prev_grant = grant;
            prev_dr    = data_ready;
        end
        chk("rnd_progress", 32'(acks > 100), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
